// File: rtl/aes_core_arb_pkg.sv
// aes_arb_pkg: shared widths, FSM state encoding and helpers for the
// two-requester AES core arbiter (aes_core_arb).
package aes_arb_pkg;

    localparam int unsigned AES_W = 128;
    localparam int unsigned NREQ  = 2;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_KLOAD = 3'd1;
    localparam state_t S_KWAIT = 3'd2;
    localparam state_t S_DLOAD = 3'd3;
    localparam state_t S_DWAIT = 3'd4;
    localparam state_t S_RESP  = 3'd5;

    function automatic logic [NREQ-1:0] req_onehot(input logic idx);
        logic [NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/aes_core_arb_if.sv
// aes_core_arb_if: requester-side job bus of aes_core_arb.
//   ReqVld/ReqKey*/ReqDin*/ReqEncDec : job request and payload (requester -> arbiter)
//   ReqAck                           : one-cycle accept pulse    (arbiter -> requester)
//   RspVld/RspDout/RspErr            : one-cycle completion      (arbiter -> requester)
// Modports: slave = arbiter side, master = requester side.
interface aes_core_arb_if;
    import aes_arb_pkg::*;

    logic [NREQ-1:0]  ReqVld;
    logic [AES_W-1:0] ReqKey0;
    logic [AES_W-1:0] ReqKey1;
    logic [AES_W-1:0] ReqDin0;
    logic [AES_W-1:0] ReqDin1;
    logic [NREQ-1:0]  ReqEncDec;
    logic [NREQ-1:0]  ReqAck;
    logic [NREQ-1:0]  RspVld;
    logic [AES_W-1:0] RspDout;
    logic             RspErr;

    modport slave (
        input  ReqVld, ReqKey0, ReqKey1, ReqDin0, ReqDin1, ReqEncDec,
        output ReqAck, RspVld, RspDout, RspErr
    );

    modport master (
        output ReqVld, ReqKey0, ReqKey1, ReqDin0, ReqDin1, ReqEncDec,
        input  ReqAck, RspVld, RspDout, RspErr
    );

endinterface

// File: rtl/aes_core_arb_rr_pick.sv
// aes_rr_pick: combinational two-way grant selection.
//   req      : pending requests
//   last_gnt : winner of the previous contested arbitration
//   gnt_vld  : some request is pending
//   gnt_idx  : granted requester
module aes_rr_pick
    import aes_arb_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic            last_gnt,
    output logic            gnt_vld,
    output logic            gnt_idx
);

    always_comb begin
        gnt_vld = |req;
        gnt_idx = 1'b0;
        case (req)
            2'b01:   gnt_idx = 1'b0;
            2'b10:   gnt_idx = 1'b1;
            2'b11:   gnt_idx = ~last_gnt;
            default: gnt_idx = 1'b0;
        endcase
    end

endmodule

// File: rtl/aes_core_arb.sv
// aes_core_arb: shares one AES core between two requesters.
// Ports:
//   CLK, RSTn           : clock, asynchronous active-low reset
//   req (slave)         : requester job bus (aes_core_arb_if)
//   Kin, Din, EncDec    : core key/data/mode buses, held between strobes
//   Krdy, Drdy, EN      : core key strobe, data strobe, core enable
//   BSY, Kvld, Dvld     : core status
//   Dout                : core result
// Parameter WDOG_CYC: cycles waited for Kvld/Dvld before the job is aborted.
// Macro AES_CORE_ARB_KEY_CACHE_EN: when defined, a job whose key and mode
// match the last successfully loaded ones skips the key load.
module aes_core_arb
    import aes_arb_pkg::*;
#(
    parameter int unsigned WDOG_CYC = 255
) (
    input  logic             CLK,
    input  logic             RSTn,
    aes_core_arb_if.slave    req,
    output logic [AES_W-1:0] Kin,
    output logic [AES_W-1:0] Din,
    output logic             Krdy,
    output logic             Drdy,
    output logic             EncDec,
    output logic             EN,
    input  logic             BSY,
    input  logic             Kvld,
    input  logic             Dvld,
    input  logic [AES_W-1:0] Dout
);

    localparam int unsigned     WD_W    = $clog2(WDOG_CYC + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYC - 1);

    state_t           state;
    logic             own;
    logic             last_gnt;
    logic [AES_W-1:0] lat_din;
    logic [WD_W-1:0]  wdog;
    logic             gnt_vld;
    logic             gnt_idx;
    logic             hit;
    logic             wd_abort;
    logic [AES_W-1:0] sel_key;
    logic [AES_W-1:0] sel_din;
    logic             sel_mode;

    aes_rr_pick u_pick (
        .req      (req.ReqVld),
        .last_gnt (last_gnt),
        .gnt_vld  (gnt_vld),
        .gnt_idx  (gnt_idx)
    );

    always_comb begin
        sel_key  = gnt_idx ? req.ReqKey1 : req.ReqKey0;
        sel_din  = gnt_idx ? req.ReqDin1 : req.ReqDin0;
        sel_mode = req.ReqEncDec[gnt_idx];
    end

    // wdog counts completed wait cycles; the last allowed one aborts unless
    // the awaited strobe arrives in that same cycle.
    assign wd_abort = (wdog == WD_LAST) &&
                      (((state == S_KWAIT) && !Kvld) || ((state == S_DWAIT) && !Dvld));

    assign Krdy = (state == S_KLOAD);
    assign Drdy = (state == S_DLOAD) && !BSY;

`ifdef AES_CORE_ARB_KEY_CACHE_EN
    logic [AES_W-1:0] ck_key;
    logic             ck_mode;
    logic             ck_vld;

    assign hit = ck_vld && (sel_key == ck_key) && (sel_mode == ck_mode);

    // Kin/EncDec still carry the key being loaded when Kvld arrives.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            ck_vld  <= 1'b0;
            ck_key  <= '0;
            ck_mode <= 1'b0;
        end else if ((state == S_KWAIT) && Kvld) begin
            ck_vld  <= 1'b1;
            ck_key  <= Kin;
            ck_mode <= EncDec;
        end else if (wd_abort) begin
            ck_vld  <= 1'b0;
        end
    end
`else
    assign hit = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state       <= S_IDLE;
            own         <= 1'b0;
            last_gnt    <= 1'b1;
            lat_din     <= '0;
            wdog        <= '0;
            Kin         <= '0;
            Din         <= '0;
            EncDec      <= 1'b0;
            EN          <= 1'b0;
            req.ReqAck  <= '0;
            req.RspVld  <= '0;
            req.RspErr  <= 1'b0;
            req.RspDout <= '0;
        end else begin
            EN         <= 1'b1;
            req.ReqAck <= '0;
            case (state)
                S_IDLE: begin
                    if (gnt_vld && !BSY) begin
                        req.ReqAck <= req_onehot(gnt_idx);
                        own        <= gnt_idx;
                        // Only contested rounds move the fairness pointer.
                        if (&req.ReqVld) last_gnt <= gnt_idx;
                        lat_din    <= sel_din;
                        if (hit) begin
                            Din   <= sel_din;
                            state <= S_DLOAD;
                        end else begin
                            Kin    <= sel_key;
                            EncDec <= sel_mode;
                            state  <= S_KLOAD;
                        end
                    end
                end
                S_KLOAD: begin
                    wdog  <= '0;
                    state <= S_KWAIT;
                end
                S_KWAIT: begin
                    if (Kvld) begin
                        Din   <= lat_din;
                        state <= S_DLOAD;
                    end else if (!wd_abort) begin
                        wdog <= wdog + 1'b1;
                    end
                end
                S_DLOAD: begin
                    if (!BSY) begin
                        wdog  <= '0;
                        state <= S_DWAIT;
                    end
                end
                S_DWAIT: begin
                    if (Dvld) begin
                        req.RspDout <= Dout;
                        req.RspVld  <= req_onehot(own);
                        req.RspErr  <= 1'b0;
                        state       <= S_RESP;
                    end else if (!wd_abort) begin
                        wdog <= wdog + 1'b1;
                    end
                end
                S_RESP: begin
                    req.RspVld <= '0;
                    req.RspErr <= 1'b0;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
            // Abort shared by both wait states; overrides the case above.
            if (wd_abort) begin
                req.RspDout <= '0;
                req.RspVld  <= req_onehot(own);
                req.RspErr  <= 1'b1;
                state       <= S_RESP;
            end
        end
    end

endmodule
